sfu_step_scheduler: RTL and testbench

Sequences the SFU (LayerNorm/special-function) datapath over a multi-step job. It issues one step request per step to the SFU core and counts `INPUT_LENGTH` result beats of `NUM_CH`×16-bit data per step. It forwards those beats as the `m_sfu_axis_*` stream toward the SFU output stage, marking step and job boundaries. It sits between `u5_sfu_top` and `u6_sfu_out_top` in `dut_top`, and is driven by `params_step_num` from `top`.

---
 rtl/sfu_step_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_sfu_step_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfu_step_scheduler.sv
// sfu_step_scheduler: sequences the SFU datapath over a multi-step job. It issues one step
// request per step, counts INPUT_LENGTH result beats per step and forwards them downstream
// with tlast on the last beat of each step.
// Optional macro SFU_SCHED_OUTREG_EN: drive the output stream from a 2-entry skid buffer.
module sfu_step_scheduler #(
    parameter int unsigned INPUT_LENGTH = 16,
    parameter int unsigned NUM_CH       = 32,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STEP_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [STEP_W-1:0]        params_step_num,
    output logic                     busy,
    output logic                     done,
    output logic                     step_req,
    input  logic                     step_ack,
    output logic [STEP_W-1:0]        step_idx,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    output logic                     m_sfu_axis_tvalid,
    input  logic                     m_sfu_axis_tready,
    output logic [NUM_CH*DATA_W-1:0] m_sfu_axis_tdata,
    output logic                     m_sfu_axis_tlast,
    output logic                     err_stray
);
    localparam int unsigned CntW = $clog2(INPUT_LENGTH);
    localparam logic [CntW-1:0] LastBeat = CntW'(INPUT_LENGTH - 1);

    typedef enum logic [1:0] {StIdle, StReq, StStream, StDone} state_e;

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [STEP_W-1:0]  step_idx_q, step_idx_d;
    logic [CntW-1:0]    beat_cnt_q, beat_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               step_req_q, step_req_d;
    logic               err_q, err_d;
    logic               in_hs;
    logic               in_last;
    logic               out_empty_next;

    assign in_hs   = s_axis_tvalid && s_axis_tready;
    assign in_last = (beat_cnt_q == LastBeat);

`ifdef SFU_SCHED_OUTREG_EN
    logic [NUM_CH*DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic                     head_last_q, head_last_d, tail_last_q, tail_last_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     rdy_q, rdy_d;
    logic                     pop;

    assign pop = (cnt_q != 2'd0) && m_sfu_axis_tready;

    // Skid buffer: pop shifts tail into head, push fills the first free slot.
    always_comb begin
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        cnt_d       = cnt_q;
        if (pop) begin
            head_data_d = tail_data_q;
            head_last_d = tail_last_q;
            cnt_d       = cnt_q - 2'd1;
        end
        if (in_hs) begin
            if (cnt_d == 2'd0) begin
                head_data_d = s_axis_tdata;
                head_last_d = in_last;
            end else begin
                tail_data_d = s_axis_tdata;
                tail_last_d = in_last;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    // Ready is registered: offer a slot only if one is free after this edge.
    assign rdy_d          = (state_d == StStream) && (cnt_d != 2'd2);
    assign out_empty_next = (cnt_d == 2'd0);

    // Skid buffer state; reset discards any buffered beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
            cnt_q       <= 2'd0;
            rdy_q       <= 1'b0;
        end else begin
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
            cnt_q       <= cnt_d;
            rdy_q       <= rdy_d;
        end
    end

    assign s_axis_tready     = rdy_q;
    assign m_sfu_axis_tvalid = (cnt_q != 2'd0);
    assign m_sfu_axis_tdata  = head_data_q;
    assign m_sfu_axis_tlast  = head_last_q;
`else
    assign s_axis_tready     = m_sfu_axis_tready && (state_q == StStream);
    assign m_sfu_axis_tvalid = s_axis_tvalid && (state_q == StStream);
    assign m_sfu_axis_tdata  = (state_q == StStream) ? s_axis_tdata : '0;
    assign m_sfu_axis_tlast  = (state_q == StStream) && in_last;
    assign out_empty_next    = 1'b1;
`endif

    // Next-state logic; done is raised one cycle early so it can be registered.
    always_comb begin
        state_d    = state_q;
        steps_d    = steps_q;
        step_idx_d = step_idx_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    err_d = 1'b0;
                    if (params_step_num != '0) begin
                        steps_d    = params_step_num;
                        step_idx_d = '0;
                        beat_cnt_d = '0;
                        state_d    = StReq;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (s_axis_tvalid) begin
                    err_d = 1'b1;
                end
            end
            StReq: begin
                if (step_req_q && step_ack) begin
                    beat_cnt_d = '0;
                    state_d    = StStream;
                end
            end
            StStream: begin
                if (in_hs) begin
                    if (in_last) begin
                        beat_cnt_d = '0;
                        if (step_idx_q == steps_q - STEP_W'(1)) begin
                            state_d = StDone;
                            done_d  = out_empty_next;
                        end else begin
                            step_idx_d = step_idx_q + STEP_W'(1);
                            state_d    = StReq;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                if (done_q) begin
                    state_d = StIdle;
                end else begin
                    done_d = out_empty_next;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d     = (state_d != StIdle);
        step_req_d = (state_d == StReq);
    end

    // FSM, counters and registered control outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            steps_q    <= '0;
            step_idx_q <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_req_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            steps_q    <= steps_d;
            step_idx_q <= step_idx_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            step_req_q <= step_req_d;
            err_q      <= err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign step_req  = step_req_q;
    assign step_idx  = step_idx_q;
    assign err_stray = err_q;
endmodule

// File: tb/tb_sfu_step_scheduler.sv
// Testbench for sfu_step_scheduler: SFU core responder, random backpressure and a
// queue-based reference model of the output stream, step indices and job completion.
module tb_sfu_step_scheduler;
    localparam int LEN    = 16;
    localparam int NUM_CH = 32;
    localparam int DATA_W = 16;
    localparam int STEP_W = 8;
    localparam int TW     = NUM_CH * DATA_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [STEP_W-1:0] params_step_num;
    logic              busy, done, step_req, step_ack;
    logic [STEP_W-1:0] step_idx;
    logic              s_axis_tvalid, s_axis_tready;
    logic [TW-1:0]     s_axis_tdata;
    logic              m_sfu_axis_tvalid, m_sfu_axis_tready, m_sfu_axis_tlast;
    logic [TW-1:0]     m_sfu_axis_tdata;
    logic              err_stray;

    sfu_step_scheduler #(
        .INPUT_LENGTH(LEN),
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .STEP_W      (STEP_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .params_step_num  (params_step_num),
        .busy             (busy),
        .done             (done),
        .step_req         (step_req),
        .step_ack         (step_ack),
        .step_idx         (step_idx),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .m_sfu_axis_tvalid(m_sfu_axis_tvalid),
        .m_sfu_axis_tready(m_sfu_axis_tready),
        .m_sfu_axis_tdata (m_sfu_axis_tdata),
        .m_sfu_axis_tlast (m_sfu_axis_tlast),
        .err_stray        (err_stray)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [TW-1:0] d;
        logic          last;
        logic          fin;
    } item_t;

    item_t         expq[$];
    int            checks = 0;
    int            failures = 0;
    logic          model_busy = 1'b0;
    logic          exp_err = 1'b0;
    logic          done_due = 1'b0;
    logic          done_seen = 1'b0;
    logic          prev_req = 1'b0;
    logic          prev_stall = 1'b0;
    logic [TW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int            exp_step = 0;
    int            job_steps = 0;
    int            in_total = 0;
    int            exp_total = 0;
    int            beats_left = 0;
    int            ack_delay = 0;
    int            src_idx = 0;
    logic          rand_ack = 1'b0;
    logic          rand_ready = 1'b0;
    logic          data_is_index = 1'b1;
    logic          stray_drive = 1'b0;

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [TW-1:0] gen_data(input int idx);
        logic [TW-1:0] v;
        v = '0;
        if (data_is_index) begin
            v = {NUM_CH{16'(idx)}};
        end else begin
            for (int k = 0; k < TW / 32; k++) v[k*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic chk_reset_values();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_step_req", step_req, 1'b0);
        chk("rst_step_idx", step_idx, '0);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_sfu_axis_tvalid, 1'b0);
        chk("rst_m_tlast", m_sfu_axis_tlast, 1'b0);
        chk("rst_m_tdata", m_sfu_axis_tdata, '0);
        chk("rst_err_stray", err_stray, 1'b0);
    endtask

    // One clock: sample and check at the falling edge, then drive after the rising edge.
    task automatic cycle();
        logic  in_hs, out_hs, req_hs, exp_done, rst_low;
        item_t it;
        @(negedge clk);
        in_hs   = s_axis_tvalid && s_axis_tready;
        out_hs  = m_sfu_axis_tvalid && m_sfu_axis_tready;
        req_hs  = step_req && step_ack;
        rst_low = !rst;
        if (!rst_low) begin
            exp_done = done_due;
            done_due = 1'b0;
            chk("done", done, exp_done);
            chk("busy", busy, model_busy);
            chk("err_stray", err_stray, exp_err);
            if (!model_busy) chk("step_req_idle", step_req, 1'b0);
            if (prev_stall) begin
                chk("hold_tvalid", m_sfu_axis_tvalid, 1'b1);
                chk("hold_tdata", m_sfu_axis_tdata, prev_data);
                chk("hold_tlast", m_sfu_axis_tlast, prev_last);
            end
            if (step_req && !prev_req) begin
                chk("step_idx", step_idx, exp_step);
                exp_step++;
            end
            prev_req = step_req;
            if (in_hs) begin
                in_total++;
                it.d    = s_axis_tdata;
                it.last = ((in_total % LEN) == 0);
                it.fin  = (in_total == exp_total);
                expq.push_back(it);
`ifndef SFU_SCHED_OUTREG_EN
                if (it.fin) done_due = 1'b1;
`endif
            end
            if (out_hs) begin
                chk("out_expected", (expq.size() != 0), 1'b1);
                if (expq.size() != 0) begin
                    it = expq.pop_front();
                    chk("out_tdata", m_sfu_axis_tdata, it.d);
                    chk("out_tlast", m_sfu_axis_tlast, it.last);
`ifdef SFU_SCHED_OUTREG_EN
                    if (it.fin) done_due = 1'b1;
`endif
                end
            end
            prev_stall = m_sfu_axis_tvalid && !m_sfu_axis_tready;
            prev_data  = m_sfu_axis_tdata;
            prev_last  = m_sfu_axis_tlast;
            if (start && !model_busy) exp_err = 1'b0;
            else if (s_axis_tvalid && !model_busy) exp_err = 1'b1;
            if (start && !model_busy) begin
                exp_step = 0;
                src_idx  = 0;
                if (params_step_num == '0) begin
                    done_due = 1'b1;
                end else begin
                    model_busy = 1'b1;
                    job_steps  = int'(params_step_num);
                    exp_total  = job_steps * LEN;
                    in_total   = 0;
                end
            end
            if (exp_done) begin
                done_seen = 1'b1;
                if (model_busy) begin
                    chk("job_steps", exp_step, job_steps);
                    chk("job_beats", in_total, exp_total);
                    chk("job_drained", expq.size(), 0);
                    model_busy = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst_low) begin
            expq.delete();
            model_busy = 1'b0;
            exp_err    = 1'b0;
            done_due   = 1'b0;
            prev_req   = 1'b0;
            prev_stall = 1'b0;
            beats_left = 0;
            step_ack   = 1'b0;
        end else begin
            if (req_hs) begin
                step_ack   = 1'b0;
                beats_left = LEN;
                ack_delay  = rand_ack ? int'($urandom_range(0, 5)) : 0;
                s_axis_tdata = gen_data(src_idx);
            end else if (step_req && !step_ack) begin
                if (ack_delay == 0) step_ack = 1'b1;
                else ack_delay--;
            end
            if (in_hs) begin
                beats_left--;
                src_idx++;
                s_axis_tdata = gen_data(src_idx);
            end
        end
        s_axis_tvalid     = (beats_left > 0) || stray_drive;
        m_sfu_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic launch(input int steps);
        done_seen       = 1'b0;
        ack_delay       = rand_ack ? int'($urandom_range(0, 5)) : 0;
        params_step_num = STEP_W'(steps);
        start           = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && !done_seen; i++) cycle();
        chk("done_seen", done_seen, 1'b1);
        repeat (3) cycle();
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 3000 && in_total < n; i++) cycle();
        chk("beats_reached", (in_total >= n), 1'b1);
    endtask

    initial begin
        rst               = 1'b0;
        start             = 1'b0;
        params_step_num   = '0;
        step_ack          = 1'b0;
        s_axis_tvalid     = 1'b0;
        s_axis_tdata      = '0;
        m_sfu_axis_tready = 1'b1;
        repeat (3) cycle();
        chk_reset_values();
        rst = 1'b1;
        repeat (2) cycle();

        // Single step, beat-index data, immediate ack, no stall.
        data_is_index = 1'b1;
        launch(1);
        wait_done();

        // Three steps with random ack delay and random data.
        data_is_index = 1'b0;
        rand_ack      = 1'b1;
        launch(3);
        wait_done();

        // Two steps under random output backpressure.
        rand_ready = 1'b1;
        launch(2);
        wait_done();
        rand_ready = 1'b0;

        // Zero-step job.
        launch(0);
        wait_done();

        // A start in the middle of a job must be ignored.
        launch(2);
        wait_beats(5);
        params_step_num = 8'd7;
        start           = 1'b1;
        cycle();
        start = 1'b0;
        wait_done();

        // Stray input while idle, then cleared by the next start.
        stray_drive = 1'b1;
        repeat (3) cycle();
        stray_drive = 1'b0;
        cycle();
        launch(1);
        wait_done();

        // Reset after beat 7 of step 0, then a normal job.
        rand_ready = 1'b1;
        launch(1);
        wait_beats(8);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk_reset_values();
        repeat (10) cycle();
        rand_ready = 1'b0;
        launch(1);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
